uart_rx_phy_param: RTL and testbench
====================================

Name: uart_rx_phy_param

Overview:
- Parametrised UART receive PHY, successor to the fixed 8N1 receiver.
- Converts the asynchronous rx_line into parallel words using oversampled majority-vote sampling.
- Supports runtime parity modes (none/even/odd), 1 or 2 stop bits, and frame/parity/overrun error reporting.
- Sits between the pad-side rx_line and the command/PWM register decoder; the consumer side uses a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..9.
- OVERSAMPLE, 16, os_tick pulses per bit; even, >=8.
- SYNC_STAGES, 2, rx_line synchroniser depth; >=2.

Ports:
- sys_clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- os_tick, in, 1, single-cycle enable at baud*OVERSAMPLE; all FSM/counter updates occur only on cycles with os_tick=1.
- rx_line, in, 1, asynchronous serial input, idle high.
- cfg_parity_en, in, 1, 1 = a parity bit follows the data bits.
- cfg_parity_odd, in, 1, 1 = odd parity, 0 = even parity.
- cfg_two_stop, in, 1, 1 = two stop bits.
- rx_data, out, DATA_WIDTH, received word, LSB first on the line.
- rx_valid, out, 1, rx_data and the error flags are valid.
- rx_ready, in, 1, consumer accepts the word.
- rx_parity_err, out, 1, parity mismatch; qualified by rx_valid.
- rx_frame_err, out, 1, a stop bit was sampled 0; qualified by rx_valid.
- rx_overrun, out, 1, one-sys_clk pulse when a frame is dropped.
- rx_break, out, 1, break indication; see Optional Feature.
- rx_busy, out, 1, FSM is not in IDLE.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; synchroniser stages preset to 1. Asserting reset mid-frame discards the frame immediately.
- Synchroniser: rx_line passes through SYNC_STAGES flops every sys_clk, giving rx_s. A 3-deep sample window (s0, s1, s2) shifts rx_s on each os_tick. The majority function maj = 2-of-3 over the window.
- tick_cnt width is clog2(OVERSAMPLE). Mid-bit point is MID = OVERSAMPLE/2. A bit is sampled as maj at tick_cnt == MID+1, covering samples MID-1..MID+1.
- IDLE:
  - A falling edge in the window (s1=1, s0=0) moves to START with tick_cnt=0.
  - cfg_* inputs are latched at this point and held constant for the frame.
- START:
  - At the sample point, maj=0 moves to DATA.
  - At the sample point, maj=1 is a false start: return to IDLE with no output.
  - tick_cnt wraps at OVERSAMPLE-1; each wrap ends one bit period.
- DATA:
  - Sample DATA_WIDTH bits into shift_reg[bit_idx]; bit_idx increments at each bit end.
  - After the last bit, go to PARITY if the latched parity_en=1, else to STOP.
- PARITY: compute exp = ^shift_reg ^ parity_odd. Set perr_int = (maj != exp).
- STOP:
  - Sample the stop bit; maj=0 sets ferr_int.
  - If two_stop=1, sample a second stop bit one period later; ferr_int ORs both samples.
  - At the sample point of the final stop bit (not the bit end), complete the frame and return to IDLE. This gives half a bit of slack for back-to-back frames.
- Completion:
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: load rx_data, rx_parity_err, rx_frame_err and set rx_valid=1 on the next cycle.
  - Otherwise keep the old word, pulse rx_overrun for 1 cycle, and discard the new frame.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1, then clears on the next cycle.
  - rx_data and the error flags are stable while rx_valid=1.
  - rx_ready while rx_valid=0 has no effect.
- rx_busy = (state != IDLE).

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined:
  - A frame whose start bit, all data bits, parity bit (if enabled) and first stop bit all sample 0 is a break.
  - On a break: no rx_valid, no overrun; rx_break pulses 1 cycle at the stop sample point.
  - The FSM then enters BRK_WAIT and returns to IDLE only after maj=1 for one full bit period.
- Not defined:
  - rx_break is tied 0 and BRK_WAIT does not exist.
  - A break is delivered as a normal word: rx_data=0, rx_frame_err=1. Parity is evaluated normally.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5, rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0xA5, perr=0, ferr=0.
- Even parity: send 0x03 with parity bit 0 -> perr=0. Resend with parity bit 1 -> rx_data=0x03, perr=1.
- Stop bit forced 0 on 0x5A -> rx_data=0x5A, ferr=1. With cfg_two_stop=1, corrupt only the second stop bit -> ferr=1.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data holds 0x11, one rx_overrun pulse. Then rx_ready=1 -> valid clears; the next 0x33 is received correctly.
- Robustness:
  - A 4-tick low glitch on idle -> false start, no output, returns to IDLE.
  - A single-tick inverted glitch at a data-bit sample point -> corrected by majority vote.
  - Assert rst_n low mid-DATA -> all outputs 0; the next clean 0x7E is received correctly.
- Break (macro on): rx_line held low for 12 bit periods -> one rx_break pulse, no rx_valid; 0x42 sent after idle is received correctly. Macro off: same stimulus -> rx_data=0x00, ferr=1.

Source files
------------

// File: rtl/uart_rx_phy_param_if.sv
// rtl/uart_rx_phy_param_if.sv - Consumer-side word handshake bundle for the UART receive PHY
interface uart_rx_phy_param_if #(
  parameter int DATA_WIDTH = 8
) ();

  // Received word plus its error flags, all qualified by rx_valid.
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  rx_parity_err;
  logic                  rx_frame_err;

  // The receiver produces words; the register decoder consumes them.
  modport master (
    output rx_data,
    output rx_valid,
    output rx_parity_err,
    output rx_frame_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_parity_err,
    input  rx_frame_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_phy_param.sv
// rtl/uart_rx_phy_param.sv - Parametrised oversampling UART receive PHY (break detection: UART_RX_BREAK_DET_EN)
module uart_rx_phy_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                os_tick_i,
  input  logic                rx_line_i,
  input  logic                cfg_parity_en_i,
  input  logic                cfg_parity_odd_i,
  input  logic                cfg_two_stop_i,
  uart_rx_phy_param_if.master rx_if,
  output logic                rx_overrun_o,
  output logic                rx_break_o,
  output logic                rx_busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  // Bits are judged on the tick after mid-bit so the 3-deep window holds MID-1..MID+1.
  localparam logic [TW-1:0] SAMPLE_TICK = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] LAST_TICK   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4
`ifdef UART_RX_BREAK_DET_EN
    , ST_BRK_WAIT = 3'd5
`endif
  } state_e;

  // Line conditioning
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [2:0]             win_q;
  logic                   maj;
  logic                   edge_seen;

  // Frame FSM and datapath
  state_e                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   two_stop_q, two_stop_d;
  logic                   stop2_q, stop2_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                   zero_q, zero_d;
`endif

  // Decoded strobes
  logic                   at_sample;
  logic                   at_bit_end;
  logic                   final_stop;
  logic                   brk_hit;
  logic                   frame_done;

  // Consumer-side registers
  logic [DATA_WIDTH-1:0]  rx_data_q;
  logic                   rx_valid_q;
  logic                   rx_perr_q;
  logic                   rx_ferr_q;
  logic                   rx_overrun_q;

  // Bring rx_line into sys_clk; presetting to 1 makes reset look like an idle line.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_line_i};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Shift the synchronised line into the 3-sample vote window once per oversample tick.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= 3'b111;
    end else if (os_tick_i) begin
      win_q <= {win_q[1:0], rx_s};
    end
  end

  // win_q[0] is the newest sample; a 1 -> 0 step between the two newest marks a start edge.
  assign maj       = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);
  assign edge_seen = win_q[1] & ~win_q[0];

  // State and frame datapath registers; a mid-frame reset drops the frame on the spot.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_BREAK_DET_EN
      zero_q     <= zero_d;
`endif
    end
  end

  // Decode sample/bit-end strobes, frame completion, break and busy from the current state.
  always_comb begin
    at_sample  = os_tick_i && (tick_q == SAMPLE_TICK);
    at_bit_end = os_tick_i && (tick_q == LAST_TICK);
    final_stop = (state_q == ST_STOP) && at_sample && (!two_stop_q || stop2_q);
    brk_hit    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk_hit    = (state_q == ST_STOP) && at_sample && !stop2_q && zero_q && !maj;
`endif
    frame_done = final_stop && !brk_hit;
    rx_busy_o  = (state_q != ST_IDLE);
  end

  // Next-state logic; START is held to its bit end so DATA begins on a bit boundary.
  always_comb begin
    state_d = state_q;
    if (os_tick_i) begin
      case (state_q)
        ST_IDLE: begin
          if (edge_seen) state_d = ST_START;
        end
        ST_START: begin
          if (at_sample && maj) begin
            state_d = ST_IDLE;
          end else if (at_bit_end) begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (at_bit_end && (bit_q == LAST_BIT)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (at_bit_end) state_d = ST_STOP;
        end
        ST_STOP: begin
          // Leaving at the sample point rather than the bit end leaves half a bit of slack.
          if (final_stop) state_d = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
          if (brk_hit) state_d = ST_BRK_WAIT;
`endif
        end
`ifdef UART_RX_BREAK_DET_EN
        ST_BRK_WAIT: begin
          if (maj && (tick_q == LAST_TICK)) state_d = ST_IDLE;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: bit timing, data capture, latched config and error accumulation.
  always_comb begin
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
`ifdef UART_RX_BREAK_DET_EN
    zero_d     = zero_q;
`endif
    if (os_tick_i) begin
      case (state_q)
        ST_IDLE: begin
          tick_d  = '0;
          bit_d   = '0;
          stop2_d = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          zero_d  = 1'b1;
`endif
          // Config is frozen at the start edge so a mid-frame change cannot split a frame.
          if (edge_seen) begin
            par_en_d   = cfg_parity_en_i;
            par_odd_d  = cfg_parity_odd_i;
            two_stop_d = cfg_two_stop_i;
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        ST_BRK_WAIT: begin
          // Counts consecutive high votes; any low vote restarts the idle-bit measurement.
          tick_d = maj ? tick_q + 1'b1 : '0;
        end
`endif
        default: begin
          tick_d = at_bit_end ? '0 : tick_q + 1'b1;
          if ((state_q == ST_DATA) && at_sample) begin
            shift_d[bit_q] = maj;
          end
          if ((state_q == ST_DATA) && at_bit_end) begin
            bit_d = bit_q + 1'b1;
          end
          if ((state_q == ST_PARITY) && at_sample) begin
            perr_d = (maj != (^shift_q ^ par_odd_q));
          end
          if ((state_q == ST_STOP) && at_sample && !maj) begin
            ferr_d = 1'b1;
          end
          if ((state_q == ST_STOP) && at_bit_end) begin
            stop2_d = 1'b1;
          end
`ifdef UART_RX_BREAK_DET_EN
          if (at_sample && (state_q != ST_STOP)) begin
            zero_d = zero_q & ~maj;
          end
          if (brk_hit) begin
            tick_d = '0;
          end
`endif
        end
      endcase
    end
  end

  // Deliver a finished frame, or drop it with an overrun pulse while the old word is pending.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= 1'b0;
      if (frame_done && (!rx_valid_q || rx_if.rx_ready)) begin
        rx_data_q  <= shift_q;
        rx_perr_q  <= perr_q;
        // The final stop vote is taken this cycle, so fold it in directly.
        rx_ferr_q  <= ferr_q | ~maj;
        rx_valid_q <= 1'b1;
      end else if (frame_done) begin
        rx_overrun_q <= 1'b1;
      end else if (rx_valid_q && rx_if.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic rx_break_q;

  // One-cycle break strobe at the first stop sample of an all-zero frame.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_break_q <= 1'b0;
    end else begin
      rx_break_q <= brk_hit;
    end
  end

  assign rx_break_o = rx_break_q;
`else
  assign rx_break_o = 1'b0;
`endif

  assign rx_if.rx_data       = rx_data_q;
  assign rx_if.rx_valid      = rx_valid_q;
  assign rx_if.rx_parity_err = rx_perr_q;
  assign rx_if.rx_frame_err  = rx_ferr_q;
  assign rx_overrun_o        = rx_overrun_q;

endmodule

// File: tb/tb_uart_rx_phy_param.sv
// tb/tb_uart_rx_phy_param.sv - Scoreboard bench for uart_rx_phy_param
module tb_uart_rx_phy_param;

  localparam int OS = 16;

  logic sys_clk        = 1'b0;
  logic rst_n          = 1'b0;
  logic os_tick        = 1'b0;
  logic rx_line        = 1'b1;
  logic cfg_parity_en  = 1'b0;
  logic cfg_parity_odd = 1'b0;
  logic cfg_two_stop   = 1'b0;
  logic rx_overrun;
  logic rx_break;
  logic rx_busy;

  uart_rx_phy_param_if #(.DATA_WIDTH(8)) rx_if ();

  uart_rx_phy_param #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk         (sys_clk),
    .rst_n           (rst_n),
    .os_tick_i       (os_tick),
    .rx_line_i       (rx_line),
    .cfg_parity_en_i (cfg_parity_en),
    .cfg_parity_odd_i(cfg_parity_odd),
    .cfg_two_stop_i  (cfg_two_stop),
    .rx_if           (rx_if),
    .rx_overrun_o    (rx_overrun),
    .rx_break_o      (rx_break),
    .rx_busy_o       (rx_busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  word_t exp_q[$];
  word_t got_w;
  word_t want_w;
  int    errors       = 0;
  int    checks       = 0;
  int    valid_cycles = 0;
  int    ovr_cycles   = 0;
  int    brk_cycles   = 0;

  initial forever #5 sys_clk = ~sys_clk;

  // os_tick: one sys_clk in four
  initial begin
    forever begin
      repeat (3) @(posedge sys_clk);
      #1 os_tick = 1'b1;
      @(posedge sys_clk);
      #1 os_tick = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run did not finish (time limit)");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every accepted word is popped and compared against the stimulus model.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (rx_if.rx_valid) valid_cycles++;
      if (rx_overrun) ovr_cycles++;
      if (rx_break) brk_cycles++;
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        got_w = {rx_if.rx_data, rx_if.rx_parity_err, rx_if.rx_frame_err};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got data=%h perr=%b ferr=%b exp=none", got_w.data, got_w.perr, got_w.ferr);
        end else begin
          want_w = exp_q.pop_front();
          if (got_w !== want_w) begin
            errors++;
            $display("FAIL word got data=%h perr=%b ferr=%b exp data=%h perr=%b ferr=%b",
                     got_w.data, got_w.perr, got_w.ferr, want_w.data, want_w.perr, want_w.ferr);
          end
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      while (os_tick !== 1'b1) @(posedge sys_clk);
    end
    #1;
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    rx_line = v;
    if (glitch) begin
      wait_ticks(8);
      rx_line = ~v;
      wait_ticks(1);
      rx_line = v;
      wait_ticks(OS - 9);
    end else begin
      wait_ticks(OS);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input bit flip_par, input bit stop1, input bit stop2,
                            input int glitch_bit, input int idle_ticks, input bit expect_it);
    logic  par;
    word_t w;
    par = (^data) ^ cfg_parity_odd ^ flip_par;
    if (expect_it) begin
      w.data = data;
      w.perr = cfg_parity_en & flip_par;
      w.ferr = ~stop1 | (cfg_two_stop & ~stop2);
      exp_q.push_back(w);
    end
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i], i == glitch_bit);
    if (cfg_parity_en) drive_bit(par, 1'b0);
    drive_bit(stop1, 1'b0);
    if (cfg_two_stop) drive_bit(stop2, 1'b0);
    rx_line = 1'b1;
    wait_ticks(idle_ticks);
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_if.rx_valid); end
    checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_if.rx_data); end
    checks++; if (rx_if.rx_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", rx_if.rx_parity_err); end
    checks++; if (rx_if.rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", rx_if.rx_frame_err); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", rx_overrun); end
    checks++; if (rx_break !== 1'b0) begin errors++; $display("FAIL reset_break got=%b exp=0", rx_break); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    rst_n = 1'b1;
    wait_ticks(2 * OS);
  endtask

  task automatic test_basic_8n1();
    int v0;
    v0 = valid_cycles;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1, 8, 1'b1);
    drain();
    checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL basic_valid_width got=%0d exp=1", valid_cycles - v0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_parity();
    cfg_parity_en  = 1'b1;
    cfg_parity_odd = 1'b0;
    send_frame(8'h03, 1'b0, 1'b1, 1'b1, -1, 8, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, -1, 8, 1'b1);
    cfg_parity_odd = 1'b1;
    send_frame(8'h5C, 1'b0, 1'b1, 1'b1, -1, 8, 1'b1);
    send_frame(8'hE7, 1'b1, 1'b1, 1'b1, -1, 8, 1'b1);
    drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL parity_drain pending=%0d exp=0", exp_q.size()); end
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;
  endtask

  task automatic test_stop_errors();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, 8, 1'b1);
    cfg_two_stop = 1'b1;
    send_frame(8'hC6, 1'b0, 1'b1, 1'b0, -1, 8, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, -1, 8, 1'b1);
    drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stop_drain pending=%0d exp=0", exp_q.size()); end
    cfg_two_stop = 1'b0;
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cycles;
    rx_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, -1, 8, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, -1, 8, 1'b0);
    checks++; if (ovr_cycles - o0 != 1) begin errors++; $display("FAIL overrun_pulses got=%0d exp=1", ovr_cycles - o0); end
    checks++; if (rx_if.rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid_held got=%b exp=1", rx_if.rx_valid); end
    checks++; if (rx_if.rx_data !== 8'h11) begin errors++; $display("FAIL overrun_data_held got=%h exp=11", rx_if.rx_data); end
    @(posedge sys_clk);
    #1 rx_if.rx_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_valid_clear got=%b exp=0", rx_if.rx_valid); end
    send_frame(8'h33, 1'b0, 1'b1, 1'b1, -1, 8, 1'b1);
    drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL overrun_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_false_start();
    int v0;
    v0 = valid_cycles;
    rx_line = 1'b0;
    wait_ticks(3);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy got=%b exp=1", rx_busy); end
    wait_ticks(1);
    rx_line = 1'b1;
    wait_ticks(2 * OS);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_start_idle got=%b exp=0", rx_busy); end
    checks++; if (valid_cycles - v0 != 0) begin errors++; $display("FAIL false_start_output got=%0d exp=0", valid_cycles - v0); end
  endtask

  task automatic test_glitch();
    send_frame(8'h96, 1'b0, 1'b1, 1'b1, 1, 8, 1'b1);
    send_frame(8'h69, 1'b0, 1'b1, 1'b1, 6, 8, 1'b1);
    drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cycles;
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, -1, 0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, -1, 8, 1'b1);
    drain();
    checks++; if (valid_cycles - v0 != 2) begin errors++; $display("FAIL b2b_words got=%0d exp=2", valid_cycles - v0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", rx_busy); end
    rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", rx_busy); end
    checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h exp=00", rx_if.rx_data); end
    checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", rx_if.rx_valid); end
    rx_line = 1'b1;
    @(posedge sys_clk);
    #1 rst_n = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1, -1, 8, 1'b1);
    drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_break();
    int    v0;
    int    b0;
    word_t w;
    v0 = valid_cycles;
    b0 = brk_cycles;
`ifndef UART_RX_BREAK_DET_EN
    w.data = 8'h00;
    w.perr = 1'b0;
    w.ferr = 1'b1;
    exp_q.push_back(w);
`endif
    rx_line = 1'b0;
    wait_ticks(12 * OS);
    rx_line = 1'b1;
    wait_ticks(2 * OS);
`ifdef UART_RX_BREAK_DET_EN
    checks++; if (brk_cycles - b0 != 1) begin errors++; $display("FAIL break_pulses got=%0d exp=1", brk_cycles - b0); end
    checks++; if (valid_cycles - v0 != 0) begin errors++; $display("FAIL break_no_valid got=%0d exp=0", valid_cycles - v0); end
`else
    checks++; if (brk_cycles - b0 != 0) begin errors++; $display("FAIL break_tied_low got=%0d exp=0", brk_cycles - b0); end
    checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL break_as_word got=%0d exp=1", valid_cycles - v0); end
`endif
    send_frame(8'h42, 1'b0, 1'b1, 1'b1, -1, 8, 1'b1);
    drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL break_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rx_if.rx_ready = 1'b1;
    test_reset();
    test_basic_8n1();
    test_parity();
    test_stop_errors();
    test_overrun();
    test_false_start();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
